// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and helpers for the SDRAM multi-port arbiter
package sdram_arb_pkg;

  // Port indices are sized for the largest supported client count.
  localparam int MAX_PORTS = 8;
  localparam int PORT_W    = $clog2(MAX_PORTS);
  localparam int CNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_RD = 2'd1,
    GNT_WR = 2'd2
  } arb_state_t;

  // Controller length code: 0 means a single word, otherwise len+2 words.
  function automatic logic [CNT_W-1:0] burst_words(input logic [3:0] len);
    if (len == 4'd0) return 5'd1;
    return {1'b0, len} + 5'd2;
  endfunction

endpackage

// File: rtl/sdram_tag_fifo.sv
// rtl/sdram_tag_fifo.sv - in-flight read burst queue of {port, remaining words}
module sdram_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [PORT_W-1:0] push_port,
  input  logic [CNT_W-1:0]  push_cnt,
  input  logic              dec,
  output logic [PORT_W-1:0] head_port,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_FILL = (AW+1)'(DEPTH);

  logic [PORT_W-1:0] port_mem [DEPTH];
  logic [CNT_W-1:0]  cnt_mem  [DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [AW:0]       fill;
  logic              do_dec, pop;

  assign empty     = (fill == '0);
  assign full      = (fill == FULL_FILL);
  assign head_port = port_mem[rd_ptr];
  assign do_dec    = dec && !empty;
  assign pop       = do_dec && (cnt_mem[rd_ptr] == CNT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      fill   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        port_mem[i] <= '0;
        cnt_mem[i]  <= '0;
      end
    end else begin
      if (push) begin
        port_mem[wr_ptr] <= push_port;
        cnt_mem[wr_ptr]  <= push_cnt;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (do_dec && !pop) cnt_mem[rd_ptr] <= cnt_mem[rd_ptr] - 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - round-robin multi-client front end for the SDRAM controller
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NPORTS   = 4,
  parameter int XWIDTH   = 20,
  parameter int DWIDTH   = 16,
  parameter int TAGDEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NPORTS-1:0]        cli_rd_req,
  input  logic [NPORTS-1:0]        cli_wr_req,
  input  logic [NPORTS*XWIDTH-1:0] cli_rd_addr,
  input  logic [NPORTS*XWIDTH-1:0] cli_wr_addr,
  input  logic [NPORTS*4-1:0]      cli_rd_len,
  input  logic [NPORTS*4-1:0]      cli_wr_len,
  input  logic [NPORTS*DWIDTH-1:0] cli_wr_data,
  output logic [NPORTS-1:0]        cli_rd_ack,
  output logic [NPORTS-1:0]        cli_wr_ack,
  output logic [NPORTS-1:0]        cli_wr_adv,
  output logic [NPORTS-1:0]        cli_rd_rdy,
  output logic [DWIDTH-1:0]        cli_rd_data,
  output logic                     mem_rd_req,
  output logic                     mem_wr_req,
  output logic [XWIDTH-1:0]        mem_rd_addr,
  output logic [XWIDTH-1:0]        mem_wr_addr,
  output logic [3:0]               mem_rd_len,
  output logic [3:0]               mem_wr_len,
  output logic [DWIDTH-1:0]        mem_wr_data,
  input  logic                     mem_rd_ack,
  input  logic                     mem_wr_ack,
  input  logic                     mem_wr_adv,
  input  logic                     mem_rd_rdy,
  input  logic [DWIDTH-1:0]        mem_rd_data,
  output logic                     err
);

  localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(NPORTS - 1);

  arb_state_t        state_q, state_d;
  logic [PORT_W-1:0] g_q, rr_ptr_q, win, cand, head_port;
  logic              found, win_rd;
  logic [MAX_PORTS-1:0] rd_elig, any_elig;
  logic [XWIDTH-1:0] win_rd_addr, win_wr_addr;
  logic [3:0]        win_rd_len, win_wr_len;
  logic [CNT_W-1:0]  wcnt_q, wcnt_after;
  logic              wr_acked_q, wr_done;
  logic              tag_push, tag_empty, tag_full;
  logic [NPORTS-1:0] head_oh;

  // Full queue blocks reads only; fill is the pre-pop value, so a same-cycle pop still holds the grant.
  assign rd_elig  = MAX_PORTS'(cli_rd_req & {NPORTS{~tag_full}});
  assign any_elig = rd_elig | MAX_PORTS'(cli_wr_req);

  always_comb begin
    found  = 1'b0;
    win    = '0;
    win_rd = 1'b0;
    cand   = '0;
    for (int k = 0; k < NPORTS; k++) begin
      cand = PORT_W'((int'(rr_ptr_q) + k) % NPORTS);
      if (!found && any_elig[cand]) begin
        found  = 1'b1;
        win    = cand;
        win_rd = rd_elig[cand];
      end
    end
  end

  always_comb begin
    win_rd_addr = '0;
    win_wr_addr = '0;
    win_rd_len  = '0;
    win_wr_len  = '0;
    head_oh     = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (win == PORT_W'(i)) begin
        win_rd_addr = cli_rd_addr[i*XWIDTH +: XWIDTH];
        win_wr_addr = cli_wr_addr[i*XWIDTH +: XWIDTH];
        win_rd_len  = cli_rd_len[i*4 +: 4];
        win_wr_len  = cli_wr_len[i*4 +: 4];
      end
      head_oh[i] = (head_port == PORT_W'(i));
    end
  end

  assign wcnt_after = (mem_wr_adv && wcnt_q != '0) ? wcnt_q - 1'b1 : wcnt_q;
  assign wr_done    = (wcnt_after == '0) && (wr_acked_q || mem_wr_ack);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = win_rd ? GNT_RD : GNT_WR;
      GNT_RD:  if (mem_rd_ack) state_d = IDLE;
      GNT_WR:  if (wr_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cli_rd_ack  = '0;
    cli_wr_ack  = '0;
    cli_wr_adv  = '0;
    mem_wr_data = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (g_q == PORT_W'(i)) begin
        if (state_q == GNT_RD) cli_rd_ack[i] = mem_rd_ack;
        if (state_q == GNT_WR) begin
          cli_wr_ack[i] = mem_wr_ack;
          cli_wr_adv[i] = mem_wr_adv;
          mem_wr_data   = cli_wr_data[i*DWIDTH +: DWIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      g_q         <= '0;
      rr_ptr_q    <= '0;
      mem_rd_req  <= 1'b0;
      mem_wr_req  <= 1'b0;
      mem_rd_addr <= '0;
      mem_wr_addr <= '0;
      mem_rd_len  <= '0;
      mem_wr_len  <= '0;
      wcnt_q      <= '0;
      wr_acked_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (found) begin
          g_q      <= win;
          rr_ptr_q <= (win == LAST_PORT) ? '0 : win + 1'b1;
          if (win_rd) begin
            mem_rd_req  <= 1'b1;
            mem_rd_addr <= win_rd_addr;
            mem_rd_len  <= win_rd_len;
          end else begin
            mem_wr_req  <= 1'b1;
            mem_wr_addr <= win_wr_addr;
            mem_wr_len  <= win_wr_len;
            wcnt_q      <= burst_words(win_wr_len);
            wr_acked_q  <= 1'b0;
          end
        end
        GNT_RD: if (mem_rd_ack) mem_rd_req <= 1'b0;
        GNT_WR: begin
          wcnt_q <= wcnt_after;
          if (mem_wr_ack) begin
            mem_wr_req <= 1'b0;
            wr_acked_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign tag_push = (state_q == GNT_RD) && mem_rd_ack;

  sdram_tag_fifo #(.DEPTH(TAGDEPTH)) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tag_push),
    .push_port (g_q),
    .push_cnt  (burst_words(mem_rd_len)),
    .dec       (mem_rd_rdy),
    .head_port (head_port),
    .empty     (tag_empty),
    .full      (tag_full)
  );

  // Returning data with nothing outstanding is dropped and latched as an error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cli_rd_rdy  <= '0;
      cli_rd_data <= '0;
      err         <= 1'b0;
    end else begin
      cli_rd_rdy <= '0;
      if (mem_rd_rdy) begin
        if (tag_empty) begin
          err <= 1'b1;
        end else begin
          cli_rd_rdy  <= head_oh;
          cli_rd_data <= mem_rd_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - scoreboard bench for the multi-port SDRAM arbiter
module tb_sdram_arbiter;

  localparam int NP = 4;
  localparam int XW = 20;
  localparam int DW = 16;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic reset;
  logic [NP-1:0]    cli_rd_req, cli_wr_req;
  logic [NP*XW-1:0] cli_rd_addr, cli_wr_addr;
  logic [NP*4-1:0]  cli_rd_len, cli_wr_len;
  logic [NP*DW-1:0] cli_wr_data;
  logic [NP-1:0]    cli_rd_ack, cli_wr_ack, cli_wr_adv, cli_rd_rdy;
  logic [DW-1:0]    cli_rd_data;
  logic             mem_rd_req, mem_wr_req;
  logic [XW-1:0]    mem_rd_addr, mem_wr_addr;
  logic [3:0]       mem_rd_len, mem_wr_len;
  logic [DW-1:0]    mem_wr_data;
  logic             mem_rd_ack, mem_wr_ack, mem_wr_adv, mem_rd_rdy;
  logic [DW-1:0]    mem_rd_data;
  logic             err;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [NP-1:0] port_oh;
    logic [DW-1:0] data;
  } rd_exp_t;
  rd_exp_t sb[$];
  rd_exp_t mon_e;

  always #5 clk = ~clk;

  sdram_arbiter #(.NPORTS(NP), .XWIDTH(XW), .DWIDTH(DW), .TAGDEPTH(TD)) dut (
    .clk(clk), .reset(reset),
    .cli_rd_req(cli_rd_req), .cli_wr_req(cli_wr_req),
    .cli_rd_addr(cli_rd_addr), .cli_wr_addr(cli_wr_addr),
    .cli_rd_len(cli_rd_len), .cli_wr_len(cli_wr_len),
    .cli_wr_data(cli_wr_data),
    .cli_rd_ack(cli_rd_ack), .cli_wr_ack(cli_wr_ack), .cli_wr_adv(cli_wr_adv),
    .cli_rd_rdy(cli_rd_rdy), .cli_rd_data(cli_rd_data),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
    .mem_rd_addr(mem_rd_addr), .mem_wr_addr(mem_wr_addr),
    .mem_rd_len(mem_rd_len), .mem_wr_len(mem_wr_len),
    .mem_wr_data(mem_wr_data),
    .mem_rd_ack(mem_rd_ack), .mem_wr_ack(mem_wr_ack), .mem_wr_adv(mem_wr_adv),
    .mem_rd_rdy(mem_rd_rdy), .mem_rd_data(mem_rd_data),
    .err(err)
  );

  // Read-return monitor: every cli_rd_rdy pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (!reset && cli_rd_rdy != '0) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL rd_return_unexpected: got rdy=%b data=%h, required no return", cli_rd_rdy, cli_rd_data);
      end else begin
        mon_e = sb.pop_front();
        if (cli_rd_rdy !== mon_e.port_oh || cli_rd_data !== mon_e.data) begin
          miscompares++;
          $display("FAIL rd_return: got rdy=%b data=%h, required rdy=%b data=%h",
                   cli_rd_rdy, cli_rd_data, mon_e.port_oh, mon_e.data);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_inputs();
    cli_rd_req = '0; cli_wr_req = '0;
    cli_rd_addr = '0; cli_wr_addr = '0;
    cli_rd_len = '0; cli_wr_len = '0;
    cli_wr_data = '0;
    mem_rd_ack = 1'b0; mem_wr_ack = 1'b0; mem_wr_adv = 1'b0;
    mem_rd_rdy = 1'b0; mem_rd_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    sb.delete();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic set_rd(input int p, input logic [XW-1:0] a, input logic [3:0] l);
    cli_rd_req[p] = 1'b1;
    cli_rd_addr[p*XW +: XW] = a;
    cli_rd_len[p*4 +: 4] = l;
  endtask

  task automatic return_word(input int p, input logic [DW-1:0] d);
    rd_exp_t e;
    e.port_oh = NP'(1 << p);
    e.data = d;
    sb.push_back(e);
    mem_rd_rdy = 1'b1;
    mem_rd_data = d;
    cyc();
    mem_rd_rdy = 1'b0;
  endtask

  task automatic grant_read(input int p);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (mem_rd_req === 1'b1) seen = 1'b1;
      else cyc();
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL rd_grant_timeout: port %0d saw no mem_rd_req in 10 cycles, required one", p);
    end else begin
      vectors++;
      if (mem_rd_addr !== cli_rd_addr[p*XW +: XW]) begin
        miscompares++;
        $display("FAIL rd_grant_addr: got %h, required %h (port %0d)", mem_rd_addr, cli_rd_addr[p*XW +: XW], p);
      end
      mem_rd_ack = 1'b1;
      #1;
      vectors++;
      if (cli_rd_ack !== NP'(1 << p)) begin
        miscompares++;
        $display("FAIL rd_ack_port: got %b, required %b", cli_rd_ack, NP'(1 << p));
      end
      cyc();
      mem_rd_ack = 1'b0;
      cli_rd_req[p] = 1'b0;
      vectors++;
      if (mem_rd_req !== 1'b0) begin
        miscompares++;
        $display("FAIL rd_req_drop: got %b, required 0", mem_rd_req);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    cyc();
    cyc();
    vectors++;
    if ({cli_rd_ack, cli_wr_ack, cli_wr_adv, cli_rd_rdy, cli_rd_data, mem_rd_req, mem_wr_req,
         mem_rd_addr, mem_wr_addr, mem_rd_len, mem_wr_len, mem_wr_data, err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got nonzero outputs rd_req=%b wr_req=%b err=%b, required all 0", mem_rd_req, mem_wr_req, err);
    end
    reset = 1'b0;
    cyc();
    vectors++;
    if ({mem_rd_req, mem_wr_req, err, cli_rd_rdy} !== '0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got rd_req=%b wr_req=%b err=%b rdy=%b, required 0", mem_rd_req, mem_wr_req, err, cli_rd_rdy);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    set_rd(2, 20'h00123, 4'd0);
    cyc();
    vectors++;
    if (mem_rd_req !== 1'b1 || mem_rd_addr !== 20'h00123 || mem_rd_len !== 4'd0) begin
      miscompares++;
      $display("FAIL single_rd_req: got req=%b addr=%h len=%h, required 1/00123/0", mem_rd_req, mem_rd_addr, mem_rd_len);
    end
    grant_read(2);
    return_word(2, 16'hBEEF);
    vectors++;
    if (cli_rd_rdy !== 4'b0100 || cli_rd_data !== 16'hBEEF) begin
      miscompares++;
      $display("FAIL single_rd_data: got rdy=%b data=%h, required 0100/beef", cli_rd_rdy, cli_rd_data);
    end
  endtask

  task automatic test_rr_order();
    do_reset();
    for (int p = 0; p < NP; p++) set_rd(p, 20'(32'h01000 + p), 4'd0);
    for (int p = 0; p < NP; p++) grant_read(p);
    do_reset();
    set_rd(1, 20'h01201, 4'd0);
    grant_read(1);
    return_word(1, 16'h1111);
    for (int p = 0; p < NP; p++) set_rd(p, 20'(32'h01100 + p), 4'd0);
    for (int k = 0; k < NP; k++) grant_read((2 + k) % NP);
    for (int k = 0; k < NP; k++) return_word((2 + k) % NP, 16'(16'h2200 + k));
  endtask

  task automatic test_write();
    logic [DW-1:0] word;
    int advs, seen_adv;
    bit adv_now;
    do_reset();
    word = 16'hA000;
    cli_wr_req[1] = 1'b1;
    cli_wr_addr[XW +: XW] = 20'h0ABCD;
    cli_wr_len[4 +: 4] = 4'd3;
    cli_wr_data[DW +: DW] = word;
    cyc();
    vectors++;
    if (mem_wr_req !== 1'b1 || mem_wr_addr !== 20'h0ABCD || mem_wr_len !== 4'd3 || mem_rd_req !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_req: got req=%b addr=%h len=%h, required 1/0abcd/3", mem_wr_req, mem_wr_addr, mem_wr_len);
    end
    advs = 0;
    seen_adv = 0;
    for (int i = 0; i < 7; i++) begin
      mem_wr_ack = (i == 0);
      mem_wr_adv = (i != 2);
      adv_now = mem_wr_adv;
      #1;
      if (cli_wr_adv[1] === 1'b1) seen_adv++;
      vectors++;
      if (advs < 5) begin
        if (mem_wr_data !== word || cli_wr_adv !== {2'b00, adv_now, 1'b0}) begin
          miscompares++;
          $display("FAIL wr_meter[%0d]: got data=%h adv=%b, required data=%h adv=%b", i, mem_wr_data, cli_wr_adv, word, {2'b00, adv_now, 1'b0});
        end
      end else if (mem_wr_data !== '0 || cli_wr_adv !== '0) begin
        miscompares++;
        $display("FAIL wr_release: got data=%h adv=%b, required 0/0000", mem_wr_data, cli_wr_adv);
      end
      if (i == 0) begin
        vectors++;
        if (cli_wr_ack !== 4'b0010) begin
          miscompares++;
          $display("FAIL wr_ack: got %b, required 0010", cli_wr_ack);
        end
      end
      cyc();
      if (i == 0) cli_wr_req[1] = 1'b0;
      if (adv_now && advs < 5) begin
        advs++;
        word = word + 1'b1;
        cli_wr_data[DW +: DW] = word;
      end
      mem_wr_ack = 1'b0;
      mem_wr_adv = 1'b0;
      if (i == 1) begin
        vectors++;
        if (mem_wr_req !== 1'b0) begin
          miscompares++;
          $display("FAIL wr_req_drop: got %b, required 0", mem_wr_req);
        end
      end
    end
    vectors++;
    if (seen_adv != 5) begin
      miscompares++;
      $display("FAIL wr_adv_count: got %0d, required 5", seen_adv);
    end
  endtask

  task automatic test_queue_full();
    do_reset();
    for (int p = 0; p < NP; p++) set_rd(p, 20'(32'h02000 + p), 4'd1);
    for (int p = 0; p < NP; p++) grant_read(p);
    set_rd(0, 20'h02100, 4'd1);
    cli_wr_req[2] = 1'b1;
    cli_wr_addr[2*XW +: XW] = 20'h02222;
    cli_wr_data[2*DW +: DW] = 16'h5A5A;
    cyc();
    vectors++;
    if (mem_wr_req !== 1'b1 || mem_rd_req !== 1'b0) begin
      miscompares++;
      $display("FAIL full_wr_grant: got wr_req=%b rd_req=%b, required 1/0", mem_wr_req, mem_rd_req);
    end
    mem_wr_ack = 1'b1;
    mem_wr_adv = 1'b1;
    #1;
    vectors++;
    if (cli_wr_ack !== 4'b0100 || mem_wr_data !== 16'h5A5A) begin
      miscompares++;
      $display("FAIL full_wr_ack: got ack=%b data=%h, required 0100/5a5a", cli_wr_ack, mem_wr_data);
    end
    cyc();
    mem_wr_ack = 1'b0;
    mem_wr_adv = 1'b0;
    cli_wr_req[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      vectors++;
      if (mem_rd_req !== 1'b0) begin
        miscompares++;
        $display("FAIL full_rd_hold[%0d]: got %b, required 0", i, mem_rd_req);
      end
    end
    for (int w = 0; w < 3; w++) begin
      return_word(0, 16'(16'h3000 + w));
      vectors++;
      if (mem_rd_req !== 1'b0) begin
        miscompares++;
        $display("FAIL full_rd_hold_ret[%0d]: got %b, required 0", w, mem_rd_req);
      end
    end
    cyc();
    vectors++;
    if (mem_rd_req !== 1'b1 || mem_rd_addr !== 20'h02100) begin
      miscompares++;
      $display("FAIL full_rd_release: got req=%b addr=%h, required 1/02100", mem_rd_req, mem_rd_addr);
    end
    grant_read(0);
    for (int p = 1; p < NP; p++)
      for (int w = 0; w < 3; w++) return_word(p, 16'(16'h3000 + 16'h100 * p + w));
    for (int w = 0; w < 3; w++) return_word(0, 16'(16'h3400 + w));
  endtask

  task automatic test_rd_before_wr();
    do_reset();
    set_rd(0, 20'h03000, 4'd0);
    cli_wr_req[0] = 1'b1;
    cli_wr_addr[0 +: XW] = 20'h03800;
    cli_wr_data[0 +: DW] = 16'h7777;
    cyc();
    vectors++;
    if (mem_rd_req !== 1'b1 || mem_wr_req !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_first: got rd_req=%b wr_req=%b, required 1/0", mem_rd_req, mem_wr_req);
    end
    grant_read(0);
    cyc();
    vectors++;
    if (mem_wr_req !== 1'b1 || mem_wr_addr !== 20'h03800) begin
      miscompares++;
      $display("FAIL wr_next: got wr_req=%b addr=%h, required 1/03800", mem_wr_req, mem_wr_addr);
    end
    mem_wr_ack = 1'b1;
    mem_wr_adv = 1'b1;
    #1;
    vectors++;
    if (cli_wr_ack !== 4'b0001 || mem_wr_data !== 16'h7777) begin
      miscompares++;
      $display("FAIL wr_next_ack: got ack=%b data=%h, required 0001/7777", cli_wr_ack, mem_wr_data);
    end
    cyc();
    mem_wr_ack = 1'b0;
    mem_wr_adv = 1'b0;
    cli_wr_req[0] = 1'b0;
    return_word(0, 16'h4242);
  endtask

  task automatic test_err();
    do_reset();
    mem_rd_rdy = 1'b1;
    mem_rd_data = 16'hDEAD;
    cyc();
    mem_rd_rdy = 1'b0;
    vectors++;
    if (err !== 1'b1 || cli_rd_rdy !== '0) begin
      miscompares++;
      $display("FAIL err_set: got err=%b rdy=%b, required 1/0000", err, cli_rd_rdy);
    end
    cyc();
    cyc();
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: got %b, required 1", err);
    end
  endtask

  task automatic test_reset_mid_write();
    cli_wr_req[2] = 1'b1;
    cli_wr_addr[2*XW +: XW] = 20'h04444;
    cli_wr_len[2*4 +: 4] = 4'd5;
    cli_wr_data[2*DW +: DW] = 16'h9999;
    cyc();
    vectors++;
    if (mem_wr_req !== 1'b1) begin
      miscompares++;
      $display("FAIL midwr_req: got %b, required 1", mem_wr_req);
    end
    mem_wr_ack = 1'b1;
    mem_wr_adv = 1'b1;
    cyc();
    mem_wr_ack = 1'b0;
    cli_wr_req[2] = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    vectors++;
    if ({cli_rd_ack, cli_wr_ack, cli_wr_adv, cli_rd_rdy, cli_rd_data, mem_rd_req, mem_wr_req,
         mem_rd_addr, mem_wr_addr, mem_rd_len, mem_wr_len, mem_wr_data, err} !== '0) begin
      miscompares++;
      $display("FAIL midwr_reset: got wr_req=%b adv=%b data=%h err=%b, required all 0", mem_wr_req, cli_wr_adv, mem_wr_data, err);
    end
    reset = 1'b0;
    clear_inputs();
    cyc();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_rr_order();
    test_write();
    test_queue_full();
    test_rd_before_wr();
    test_err();
    test_reset_mid_write();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: got %0d pending read words, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
